spi_flash_cmd_master: RTL and testbench
=======================================

# spi_flash_cmd_master

Parametrised SPI mode-0 master that runs a complete serial-flash command (opcode, optional address, optional write payload, optional read payload) framed by one `chip_select` assertion. It replaces the fixed-function RDID engine and sits between system logic and an M25P16-class flash. It supports RDID, READ, WREN, page program and any other opcode expressible as cmd + addr + write bytes + read bytes. The SPI clock is derived from `clk` by a programmable divider.

## Interface
- `CLK_DIV`, default 1: SPICLK half-period in `clk` cycles (≥1); 1 gives SPICLK = clk/2.
- `LEN_W`, default 8: width of `wr_len`/`rd_len`; max payload 2^LEN_W−1 bytes each.
- `CS_IDLE`, default 2: minimum `clk` cycles `chip_select` stays high between transfers (≥1).

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; accepted on a `clk` edge where `start`=1 and `busy`=0.
- `cmd`  in  8  opcode, captured at accept.
- `addr`  in  24  address, captured at accept; sent MSB-first, low `addr_len` bytes only.
- `addr_len`  in  2  address bytes, 0–3, captured at accept.
- `wr_len`  in  LEN_W  write payload bytes, captured at accept.
- `rd_len`  in  LEN_W  read payload bytes, captured at accept.
- `wr_data`  in  8  write byte; must be valid in any cycle `wr_req`=1.
- `wr_req`  out  1  one-cycle pulse; `wr_data` captured at the end of that cycle.
- `rd_data`  out  8  last received byte; holds until the next byte.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is new.
- `busy`  out  1  transfer in progress or CS idle time running.
- `done`  out  1  one-cycle pulse at transfer end.
- `SPICLK`  out  1  SPI clock, idle low.
- `SPIMOSI`  out  1  master data out, MSB-first.
- `SPIMISO`  in  1  slave data in.
- `chip_select`  out  1  active-low slave select.

## Operation
- Reset values: `chip_select`=1, `SPICLK`=0, `SPIMOSI`=0, `busy`=0, `done`=0, `wr_req`=0, `rd_valid`=0, `rd_data`=0.
- States: IDLE → SHIFT → CS_GAP → IDLE.
  - IDLE: wait for accept.
  - SHIFT: N = 8·(1 + addr_len + wr_len + rd_len) bits. Phases are CMD, ADDR, WRITE, READ. A zero-length phase is skipped.
  - CS_GAP: `chip_select` high; counts CS_IDLE cycles, then returns to IDLE.
- MOSI carries cmd, then addr bytes, then write bytes. During READ, MOSI is driven 0.
- MISO is shifted in only during the READ phase; bits in other phases are ignored.
- `start` while `busy`=1 is ignored; it is not queued.
- Reset mid-transfer: on the next edge all outputs take their reset values, with no `done` and no partial `rd_valid`.
- No back-pressure on either stream. The write source must always have data ready; the read sink must accept every `rd_valid`.

## Timing
D = CLK_DIV. E0 is the accept edge; times are counted in `clk` edges after E0.
- From E0: `chip_select`=0, `busy`=1, `SPIMOSI`=cmd[7], `SPICLK`=0.
- Bit i (0..N−1):
  - `SPICLK` rises at E0+(2i+1)D.
  - `SPICLK` falls at E0+(2i+2)D.
  - `SPIMISO` is sampled at the rising edge (value present just before that edge).
  - `SPIMOSI` changes only at falling edges, to bit i+1.
- Write byte k: its first bit is index f. `wr_req` is high in the cycle ending at edge E0+(2f−1)D. The byte is captured there and driven from the falling edge at E0+2f·D.
- Read byte: `rd_data` and `rd_valid` update on the edge that samples the byte's bit 0.
- End of transfer:
  - Last falling edge at E0+2N·D.
  - At E0+(2N+1)D: `chip_select`=1 and `done`=1 for one cycle.
  - `busy` drops CS_IDLE cycles later.
  - The earliest next accept is the edge after `busy` drops.
- SPICLK period = 2D `clk` cycles. Exactly N SPICLK rising edges per transfer.

## Test plan
- RDID, D=1, cmd=0x9F, addr_len=0, wr_len=0, rd_len=3, flash model attached:
  - MOSI=1001_1111; 32 SPICLK rises.
  - `rd_valid` ×3 with 0x20, 0x20, 0x15.
  - `chip_select` low 65 cycles; one `done`.
- WREN, cmd=0x06, all lengths 0:
  - 8 SPICLK rises, no `wr_req`/`rd_valid`, `done` at E0+17.
- READ, D=3, cmd=0x03, addr=0x000100, addr_len=3, rd_len=4:
  - SPICLK period 6 cycles; 64 rises.
  - MOSI shows 0x03, 0x00, 0x01, 0x00; 4 `rd_valid` matching model memory.
- Page program, cmd=0x02, addr_len=3, wr_len=2, source 0xA5 then 0x3C:
  - Exactly 2 `wr_req` pulses at the specified edges.
  - MOSI bits 32–47 = 0xA53C.
- `start` held high continuously, CS_IDLE=2:
  - Second transfer accepted exactly 3 edges after `chip_select` rises.
  - Pulses of `start` mid-transfer are ignored.
- `reset` asserted during the ADDR phase:
  - Next edge gives `chip_select`=1, `SPICLK`=0, `busy`=0, no `done`.
  - A following RDID returns 0x20, 0x20, 0x15.

Source files
------------

// File: rtl/spi_flash_cmd_if.sv
// spi_flash_cmd_if: command/data bus of spi_flash_cmd_master; master = system side, slave = engine side
interface spi_flash_cmd_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [7:0]       cmd;
  logic [23:0]      addr;
  logic [1:0]       addr_len;
  logic [LEN_W-1:0] wr_len;
  logic [LEN_W-1:0] rd_len;
  logic [7:0]       wr_data;
  logic             wr_req;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  modport master (
    output start, cmd, addr, addr_len, wr_len, rd_len, wr_data,
    input  wr_req, rd_data, rd_valid, busy, done
  );
  modport slave (
    input  start, cmd, addr, addr_len, wr_len, rd_len, wr_data,
    output wr_req, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/spi_flash_cmd_master.sv
// spi_flash_cmd_master: SPI mode-0 flash command engine (cmd, addr, write, read bytes in one CS frame); ports clk, reset, bus (command if), SPICLK, SPIMOSI, SPIMISO, chip_select
module spi_flash_cmd_master #(
  parameter int CLK_DIV = 1,
  parameter int LEN_W   = 8,
  parameter int CS_IDLE = 2
) (
  input  logic           clk,
  input  logic           reset,
  spi_flash_cmd_if.slave bus,
  output logic           SPICLK,
  output logic           SPIMOSI,
  input  logic           SPIMISO,
  output logic           chip_select
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int GW = CS_IDLE > 1 ? $clog2(CS_IDLE) : 1;
  localparam int BW = LEN_W + 2;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] CS_GAP = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [BW-1:0] byte_idx, addr_end, wr_end, total, nxt;
  logic [2:0]    bit_idx;
  logic [7:0]    tx, wr_buf, rx, nb;
  logic [23:0]   addr_sh;
  logic          tick, in_rd, wr_fire;
  always_comb begin
    tick    = div_cnt == CW'(CLK_DIV - 1);
    nxt     = byte_idx + BW'(1);
    in_rd   = byte_idx >= wr_end && byte_idx < total;
    nb      = nxt < addr_end ? addr_sh[23:16] : nxt < wr_end ? wr_buf : 8'h00;
    wr_fire = state == SHIFT && tick && !SPICLK && bit_idx == 3'd7 && nxt >= addr_end && nxt < wr_end;
  end
  assign bus.wr_req = wr_fire;
  assign bus.busy   = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      SPICLK       <= 1'b0;
      SPIMOSI      <= 1'b0;
      chip_select  <= 1'b1;
      bus.done     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= 8'h00;
      div_cnt      <= '0;
      gap_cnt      <= '0;
      byte_idx     <= '0;
      bit_idx      <= '0;
      addr_end     <= '0;
      wr_end       <= '0;
      total        <= '0;
      tx           <= '0;
      wr_buf       <= '0;
      rx           <= '0;
      addr_sh      <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.rd_valid <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state       <= SHIFT;
          chip_select <= 1'b0;
          SPIMOSI     <= bus.cmd[7];
          tx          <= {bus.cmd[6:0], 1'b0};
          addr_sh     <= bus.addr << (5'd24 - {bus.addr_len, 3'b000});
          addr_end    <= BW'(bus.addr_len) + BW'(1);
          wr_end      <= BW'(bus.addr_len) + BW'(bus.wr_len) + BW'(1);
          total       <= BW'(bus.addr_len) + BW'(bus.wr_len) + BW'(bus.rd_len) + BW'(1);
          byte_idx    <= '0;
          bit_idx     <= '0;
          div_cnt     <= '0;
        end
        SHIFT: if (!tick) div_cnt <= div_cnt + CW'(1);
        else begin
          div_cnt <= '0;
          if (!SPICLK) begin
            if (byte_idx == total) begin
              state       <= CS_GAP;
              chip_select <= 1'b1;
              bus.done    <= 1'b1;
              gap_cnt     <= '0;
            end else begin
              SPICLK <= 1'b1;
              if (in_rd) rx <= {rx[6:0], SPIMISO};
              if (in_rd && bit_idx == 3'd7) begin
                bus.rd_data  <= {rx[6:0], SPIMISO};
                bus.rd_valid <= 1'b1;
              end
              if (wr_fire) wr_buf <= bus.wr_data;
            end
          end else begin
            SPICLK  <= 1'b0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              byte_idx <= nxt;
              SPIMOSI  <= nb[7];
              tx       <= {nb[6:0], 1'b0};
              if (nxt < addr_end) addr_sh <= addr_sh << 8;
            end else begin
              SPIMOSI <= tx[7];
              tx      <= {tx[6:0], 1'b0};
            end
          end
        end
        CS_GAP: if (gap_cnt == GW'(CS_IDLE - 1)) state <= IDLE;
        else gap_cnt <= gap_cnt + GW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_cmd_master.sv
// tb_spi_flash_cmd_master: directed bench with flash model; instance a uses CLK_DIV=1, instance b CLK_DIV=3
module tb_spi_flash_cmd_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr = 1'b0;
  logic wsel = 1'b0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int e0, rise_e, n;
  wire  [1:0] sclk_v, mosi_v, cs_v;
  logic [1:0] miso_v = 2'b00;
  logic [1:0] psclk = 2'b00;
  wire  [1:0] rdv, wrq, dn;
  wire  [7:0] rdd [2];
  int rises[2], rd_n[2], wr_n[2], done_n[2], cs_low[2], done_c[2];
  int rise_c[2][2], wr_c[2][2];
  logic [63:0] mbits[2];
  logic [7:0]  rxb[2][8];
  int          fcnt[2] = '{0, 0};
  logic [31:0] fsr[2];
  logic [7:0]  fop[2] = '{8'h00, 8'h00};
  logic [23:0] fad[2];

  spi_flash_cmd_if #(.LEN_W(8)) busa();
  spi_flash_cmd_if #(.LEN_W(8)) busb();

  spi_flash_cmd_master #(.CLK_DIV(1), .LEN_W(8), .CS_IDLE(2)) u_a (
    .clk(clk), .reset(reset), .bus(busa.slave), .SPICLK(sclk_v[0]),
    .SPIMOSI(mosi_v[0]), .SPIMISO(miso_v[0]), .chip_select(cs_v[0])
  );
  spi_flash_cmd_master #(.CLK_DIV(3), .LEN_W(8), .CS_IDLE(2)) u_b (
    .clk(clk), .reset(reset), .bus(busb.slave), .SPICLK(sclk_v[1]),
    .SPIMOSI(mosi_v[1]), .SPIMISO(miso_v[1]), .chip_select(cs_v[1])
  );

  assign rdv = {busb.rd_valid, busa.rd_valid};
  assign wrq = {busb.wr_req, busa.wr_req};
  assign dn  = {busb.done, busa.done};
  assign rdd[0] = busa.rd_data;
  assign rdd[1] = busb.rd_data;
  assign busa.wr_data = wsel ? 8'h3C : 8'hA5;
  assign busb.wr_data = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (busa.wr_req) wsel <= ~wsel;

  function automatic logic fbit(input logic [7:0] op, input logic [23:0] a, input int cnt);
    int hdr, idx;
    logic [7:0] b;
    logic [23:0] ba;
    hdr = op == 8'h9F ? 8 : 32;
    if (!(op == 8'h9F || op == 8'h03) || cnt < hdr) return 1'b0;
    idx = cnt - hdr;
    if (op == 8'h9F) b = idx / 8 == 0 ? 8'h20 : idx / 8 == 1 ? 8'h20 : idx / 8 == 2 ? 8'h15 : 8'h00;
    else begin
      ba = a + 24'(idx / 8);
      b  = ba[7:0] ^ 8'h5A;
    end
    return b[7 - (idx % 8)];
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        rises[k] <= 0; rd_n[k] <= 0; wr_n[k] <= 0; done_n[k] <= 0; cs_low[k] <= 0;
        done_c[k] <= 0; mbits[k] <= '0;
      end else begin
        if (sclk_v[k] && !psclk[k]) begin
          if (rises[k] < 2) rise_c[k][rises[k]] <= cyc;
          rises[k] <= rises[k] + 1;
          mbits[k] <= {mbits[k][62:0], mosi_v[k]};
        end
        if (rdv[k]) begin
          if (rd_n[k] < 8) rxb[k][rd_n[k]] <= rdd[k];
          rd_n[k] <= rd_n[k] + 1;
        end
        if (wrq[k]) begin
          if (wr_n[k] < 2) wr_c[k][wr_n[k]] <= cyc + 1;
          wr_n[k] <= wr_n[k] + 1;
        end
        if (dn[k]) begin
          done_c[k] <= cyc;
          done_n[k] <= done_n[k] + 1;
        end
        if (!cs_v[k]) cs_low[k] <= cs_low[k] + 1;
      end
      psclk[k] <= sclk_v[k];
      if (cs_v[k]) begin
        fcnt[k] <= 0;
        miso_v[k] <= 1'b0;
      end else if (sclk_v[k] && !psclk[k]) begin
        fsr[k] <= {fsr[k][30:0], mosi_v[k]};
        if (fcnt[k] == 7) fop[k] <= {fsr[k][6:0], mosi_v[k]};
        if (fcnt[k] == 31) fad[k] <= {fsr[k][22:0], mosi_v[k]};
        fcnt[k] <= fcnt[k] + 1;
      end else if (!sclk_v[k] && psclk[k]) miso_v[k] <= fbit(fop[k], fad[k], fcnt[k]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic go(input int k, input logic [7:0] c, input logic [23:0] a, input logic [1:0] al,
                    input logic [7:0] wl, input logic [7:0] rl, input bit keep);
    clr = 1'b1;
    @(negedge clk);
    #1;
    clr = 1'b0;
    if (k == 0) begin
      busa.cmd = c; busa.addr = a; busa.addr_len = al; busa.wr_len = wl; busa.rd_len = rl; busa.start = 1'b1;
    end else begin
      busb.cmd = c; busb.addr = a; busb.addr_len = al; busb.wr_len = wl; busb.rd_len = rl; busb.start = 1'b1;
    end
    @(posedge clk);
    #1;
    e0 = cyc;
    if (!keep) begin
      busa.start = 1'b0;
      busb.start = 1'b0;
    end
  endtask

  task automatic wait_idle(input int k, input int lim);
    int cnt = 0;
    while ((k == 0 ? busa.busy : busb.busy) && cnt < lim) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("idle_timeout", k == 0 ? busa.busy : busb.busy, 0);
  endtask

  initial begin
    busa.start = 1'b0; busa.cmd = '0; busa.addr = '0; busa.addr_len = '0; busa.wr_len = '0; busa.rd_len = '0;
    busb.start = 1'b0; busb.cmd = '0; busb.addr = '0; busb.addr_len = '0; busb.wr_len = '0; busb.rd_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {cs_v[0], sclk_v[0], mosi_v[0], busa.busy, busa.done, busa.wr_req, busa.rd_valid}, 7'b1000000);
    chk("reset_rd_data", busa.rd_data, 8'h00);
    reset = 1'b0;
    go(0, 8'h9F, 24'h0, 2'd0, 8'd0, 8'd3, 1'b0);
    chk("rdid_e0", {cs_v[0], busa.busy, mosi_v[0], sclk_v[0]}, 4'b0110);
    wait_idle(0, 200);
    chk("rdid_rises", rises[0], 32);
    chk("rdid_mosi", mbits[0][31:0], 32'h9F000000);
    chk("rdid_rd_n", rd_n[0], 3);
    chk("rdid_bytes", {rxb[0][0], rxb[0][1], rxb[0][2]}, 24'h202015);
    chk("rdid_cs_low", cs_low[0], 65);
    chk("rdid_done_n", done_n[0], 1);
    chk("rdid_done_at", done_c[0] - e0, 65);
    chk("rdid_wr_n", wr_n[0], 0);
    go(0, 8'h06, 24'h0, 2'd0, 8'd0, 8'd0, 1'b0);
    wait_idle(0, 100);
    chk("wren_rises", rises[0], 8);
    chk("wren_mosi", mbits[0][7:0], 8'h06);
    chk("wren_no_wr_rd", wr_n[0] + rd_n[0], 0);
    chk("wren_done_at", done_c[0] - e0, 17);
    go(1, 8'h03, 24'h000100, 2'd3, 8'd0, 8'd4, 1'b0);
    wait_idle(1, 1000);
    chk("read_rises", rises[1], 64);
    chk("read_first_rise", rise_c[1][0] - e0, 3);
    chk("read_period", rise_c[1][1] - rise_c[1][0], 6);
    chk("read_mosi", mbits[1][63:32], 32'h03000100);
    chk("read_rd_n", rd_n[1], 4);
    chk("read_bytes", {rxb[1][0], rxb[1][1], rxb[1][2], rxb[1][3]}, 32'h5A5B5859);
    chk("read_done_at", done_c[1] - e0, 387);
    go(0, 8'h02, 24'h001234, 2'd3, 8'd2, 8'd0, 1'b0);
    wait_idle(0, 200);
    chk("pp_wr_n", wr_n[0], 2);
    chk("pp_wr0_at", wr_c[0][0] - e0, 63);
    chk("pp_wr1_at", wr_c[0][1] - e0, 79);
    chk("pp_hdr", mbits[0][47:16], 32'h02001234);
    chk("pp_data", mbits[0][15:0], 16'hA53C);
    chk("pp_rises", rises[0], 48);
    chk("pp_done_at", done_c[0] - e0, 97);
    go(0, 8'h06, 24'h0, 2'd0, 8'd0, 8'd0, 1'b1);
    n = 0;
    while (!cs_v[0] && n < 100) begin @(posedge clk); #1; n++; end
    rise_e = cyc;
    chk("hold_cs_rise_at", rise_e - e0, 17);
    n = 0;
    while (cs_v[0] && n < 100) begin @(posedge clk); #1; n++; end
    busa.start = 1'b0;
    chk("hold_reaccept", cyc - rise_e, 3);
    wait_idle(0, 100);
    chk("hold_done_n", done_n[0], 2);
    chk("hold_cs_low", cs_low[0], 34);
    go(0, 8'h06, 24'h0, 2'd0, 8'd0, 8'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    busa.start = 1'b1;
    @(posedge clk);
    #1;
    busa.start = 1'b0;
    wait_idle(0, 100);
    repeat (4) @(posedge clk);
    #1;
    chk("pulse_cs_low", cs_low[0], 17);
    chk("pulse_done_n", done_n[0], 1);
    go(0, 8'h03, 24'h000100, 2'd3, 8'd0, 8'd4, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid", {cs_v[0], sclk_v[0], busa.busy, busa.done, mosi_v[0], busa.rd_valid}, 6'b100000);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_done", done_n[0], 0);
    chk("rst_no_rd", rd_n[0], 0);
    go(0, 8'h9F, 24'h0, 2'd0, 8'd0, 8'd3, 1'b0);
    wait_idle(0, 200);
    chk("rst_rdid_rd_n", rd_n[0], 3);
    chk("rst_rdid_bytes", {rxb[0][0], rxb[0][1], rxb[0][2]}, 24'h202015);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
